// File: rtl/dcache_controller.sv
// Data-cache controller: a write-back, write-allocate miss handler that sits
// between the CPU load/store port, a tag/data SRAM and a line-wide memory.
// Optional hit/miss performance counters are built when the macro
// DCACHE_PERF_CNT_EN is defined; the default build omits them entirely.
module dcache_controller #(
    parameter int CNT_W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    input  logic         cpu_MemRead_i,
    input  logic         cpu_MemWrite_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
    output logic [3:0]   cache_sram_index_o,
    output logic [24:0]  cache_sram_tag_o,
    output logic [255:0] cache_sram_data_o,
    output logic         cache_sram_enable_o,
    output logic         cache_sram_write_o,
    input  logic [24:0]  cache_sram_tag_i,
    input  logic [255:0] cache_sram_data_i,
    input  logic         cache_sram_hit_i
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
`endif
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] MISS       = 3'd1;
    localparam logic [2:0] WRITEBACK  = 3'd2;
    localparam logic [2:0] READMISS   = 3'd3;
    localparam logic [2:0] READMISSOK = 3'd4;

    logic [2:0]   state;
    logic [2:0]   next_state;
    logic [255:0] fill_buf;
    logic [255:0] merged_line;

    logic         req;
    logic         is_store;
    logic [3:0]   index;
    logic [2:0]   word_sel;
    logic [22:0]  cpu_tag;
    logic         victim_dirty;

    assign req          = cpu_MemRead_i | cpu_MemWrite_i;
    assign is_store     = cpu_MemWrite_i;  // store wins when both strobes are high
    assign index        = cpu_addr_i[8:5];
    assign word_sel     = cpu_addr_i[4:2];
    assign cpu_tag      = cpu_addr_i[31:9];
    assign victim_dirty = cache_sram_tag_i[24] & cache_sram_tag_i[23];

    // Byte offset bits below word granularity are never needed.
    logic unused_ok;
    assign unused_ok = ^cpu_addr_i[1:0];

    assign cache_sram_index_o  = index;
    assign cache_sram_enable_o = req;
    assign cpu_data_o          = cache_sram_data_i[{word_sel, 5'b0} +: 32];

    // Store-hit line: the current line with the addressed word replaced.
    always_comb begin
        merged_line = cache_sram_data_i;
        merged_line[{word_sel, 5'b0} +: 32] = cpu_data_i;
    end

    // State register; reset abandons any memory transfer in flight.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from the same pre-edge values.
        if (rst_i) state <= IDLE;
        else       state <= next_state;
    end

    // Fill buffer captures the memory line on the completing ack.
    always_ff @(posedge clk_i) begin
        if (rst_i)                                fill_buf <= '0;
        else if (state == READMISS && mem_ack_i)  fill_buf <= mem_data_i;
    end

    // Next-state logic; ack only matters while a transfer is outstanding.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (req && !cache_sram_hit_i) next_state = MISS;
            MISS:       next_state = victim_dirty ? WRITEBACK : READMISS;
            WRITEBACK:  if (mem_ack_i) next_state = READMISS;
            READMISS:   if (mem_ack_i) next_state = READMISSOK;
            READMISSOK: next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    // Output decode for the CPU, memory and SRAM write ports.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        cpu_stall_o        = 1'b1;
        mem_enable_o       = 1'b0;
        mem_write_o        = 1'b0;
        mem_addr_o         = '0;
        mem_data_o         = '0;
        cache_sram_write_o = 1'b0;
        cache_sram_tag_o   = '0;
        cache_sram_data_o  = '0;
        case (state)
            IDLE: begin
                cpu_stall_o = req & ~cache_sram_hit_i;
                if (req && cache_sram_hit_i && is_store) begin
                    cache_sram_write_o = 1'b1;
                    cache_sram_tag_o   = {1'b1, 1'b1, cpu_tag};
                    cache_sram_data_o  = merged_line;
                end
            end
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {cache_sram_tag_i[22:0], index, 5'b0};
                mem_data_o   = cache_sram_data_i;
            end
            READMISS: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {cpu_addr_i[31:5], 5'b0};
            end
            READMISSOK: begin
                cache_sram_write_o = 1'b1;
                cache_sram_tag_o   = {1'b1, 1'b0, cpu_tag};
                cache_sram_data_o  = fill_buf;
            end
            default: ;
        endcase
    end

`ifdef DCACHE_PERF_CNT_EN
    // Saturating hit and miss counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (state == IDLE && req && cache_sram_hit_i && hit_cnt_o != '1)
                hit_cnt_o <= hit_cnt_o + 1'b1;
            if (state == IDLE && next_state == MISS && miss_cnt_o != '1)
                miss_cnt_o <= miss_cnt_o + 1'b1;
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller. A small direct-mapped tag/data array
// stands in for the cache SRAM; memory responses are driven by hand.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [3:0]   cache_sram_index_o;
    logic [24:0]  cache_sram_tag_o;
    logic [255:0] cache_sram_data_o;
    logic         cache_sram_enable_o;
    logic         cache_sram_write_o;
    logic [24:0]  cache_sram_tag_i;
    logic [255:0] cache_sram_data_i;
    logic         cache_sram_hit_i;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;

    logic [24:0]  tag_arr  [16];
    logic [255:0] data_arr [16];

    always #5 clk_i = ~clk_i;

    dcache_controller #(.CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
        .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .cache_sram_index_o(cache_sram_index_o), .cache_sram_tag_o(cache_sram_tag_o),
        .cache_sram_data_o(cache_sram_data_o), .cache_sram_enable_o(cache_sram_enable_o),
        .cache_sram_write_o(cache_sram_write_o), .cache_sram_tag_i(cache_sram_tag_i),
        .cache_sram_data_i(cache_sram_data_i), .cache_sram_hit_i(cache_sram_hit_i)
`ifdef DCACHE_PERF_CNT_EN
        , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
    );

    // Direct-mapped SRAM model: combinational lookup, write on the clock edge.
    assign cache_sram_tag_i  = tag_arr[cache_sram_index_o];
    assign cache_sram_data_i = data_arr[cache_sram_index_o];
    assign cache_sram_hit_i  = tag_arr[cache_sram_index_o][24] &&
                               (tag_arr[cache_sram_index_o][22:0] == cpu_addr_i[31:9]);

    always @(posedge clk_i) begin
        if (cache_sram_enable_o && cache_sram_write_o) begin
            tag_arr[cache_sram_index_o]  <= cache_sram_tag_o;
            data_arr[cache_sram_index_o] <= cache_sram_data_o;
            wr_cnt <= wr_cnt + 1;
        end
    end

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = base + w;
        return l;
    endfunction

    task automatic test_reset();
        rst_i = 1'b1; cpu_addr_i = '0; cpu_data_i = '0;
        cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
        mem_data_i = '0; mem_ack_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tag_arr[i]  <= '0;
            data_arr[i] <= '0;
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        n_cmp++; if (cpu_stall_o !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", cpu_stall_o); end
        n_cmp++; if (mem_enable_o !== 1'b0) begin n_bad++; $display("FAIL rst_mem_enable: got %b want 0", mem_enable_o); end
        n_cmp++; if (cache_sram_write_o !== 1'b0) begin n_bad++; $display("FAIL rst_sram_write: got %b want 0", cache_sram_write_o); end
        n_cmp++; if (mem_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr_o); end
`ifdef DCACHE_PERF_CNT_EN
        n_cmp++; if (hit_cnt_o !== 32'h0) begin n_bad++; $display("FAIL rst_hit_cnt: got %0d want 0", hit_cnt_o); end
        n_cmp++; if (miss_cnt_o !== 32'h0) begin n_bad++; $display("FAIL rst_miss_cnt: got %0d want 0", miss_cnt_o); end
`endif
    endtask

    task automatic test_read_hit();
        logic [255:0] line;
        line = make_line(32'h1111_0000);
        line[63:32] = 32'hDEAD_BEEF;
        tag_arr[2]  <= {1'b1, 1'b0, 23'h0};
        data_arr[2] <= line;
        @(negedge clk_i);
        cpu_addr_i = 32'h0000_0044; cpu_MemRead_i = 1'b1;
        #1;
        n_cmp++; if (cpu_data_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_hit_data: got %h want deadbeef", cpu_data_o); end
        n_cmp++; if (cpu_stall_o !== 1'b0) begin n_bad++; $display("FAIL rd_hit_stall: got %b want 0", cpu_stall_o); end
        n_cmp++; if (cache_sram_index_o !== 4'd2) begin n_bad++; $display("FAIL rd_hit_index: got %0d want 2", cache_sram_index_o); end
        n_cmp++; if (cache_sram_enable_o !== 1'b1) begin n_bad++; $display("FAIL rd_hit_sram_en: got %b want 1", cache_sram_enable_o); end
        n_cmp++; if (cache_sram_write_o !== 1'b0) begin n_bad++; $display("FAIL rd_hit_sram_write: got %b want 0", cache_sram_write_o); end
        @(negedge clk_i);
        cpu_MemRead_i = 1'b0;
    endtask

    task automatic test_write_hit();
        logic [255:0] exp_line;
        int wc0;
        exp_line = make_line(32'h1111_0000);
        exp_line[63:32] = 32'hDEAD_BEEF;
        exp_line[95:64] = 32'h1234_5678;
        wc0 = wr_cnt;
        cpu_addr_i = 32'h0000_0048; cpu_data_i = 32'h1234_5678; cpu_MemWrite_i = 1'b1;
        #1;
        n_cmp++; if (cpu_stall_o !== 1'b0) begin n_bad++; $display("FAIL wr_hit_stall: got %b want 0", cpu_stall_o); end
        n_cmp++; if (cache_sram_write_o !== 1'b1) begin n_bad++; $display("FAIL wr_hit_sram_write: got %b want 1", cache_sram_write_o); end
        n_cmp++; if (cache_sram_tag_o !== {1'b1, 1'b1, 23'h0}) begin n_bad++; $display("FAIL wr_hit_tag: got %h want %h", cache_sram_tag_o, {1'b1, 1'b1, 23'h0}); end
        n_cmp++; if (cache_sram_data_o !== exp_line) begin n_bad++; $display("FAIL wr_hit_line: got %h want %h", cache_sram_data_o, exp_line); end
        @(negedge clk_i);
        cpu_MemWrite_i = 1'b0;
        #1;
        n_cmp++; if (wr_cnt !== wc0 + 1) begin n_bad++; $display("FAIL wr_hit_write_count: got %0d want %0d", wr_cnt, wc0 + 1); end
        n_cmp++; if (data_arr[2] !== exp_line) begin n_bad++; $display("FAIL wr_hit_stored: got %h want %h", data_arr[2], exp_line); end
        n_cmp++; if (cache_sram_write_o !== 1'b0) begin n_bad++; $display("FAIL wr_hit_write_drop: got %b want 0", cache_sram_write_o); end
    endtask

    task automatic test_both_high();
        @(negedge clk_i);
        cpu_addr_i = 32'h0000_004C; cpu_data_i = 32'hA5A5_A5A5;
        cpu_MemRead_i = 1'b1; cpu_MemWrite_i = 1'b1;
        #1;
        n_cmp++; if (cache_sram_write_o !== 1'b1) begin n_bad++; $display("FAIL both_sram_write: got %b want 1", cache_sram_write_o); end
        n_cmp++; if (cache_sram_data_o[127:96] !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL both_word3: got %h want a5a5a5a5", cache_sram_data_o[127:96]); end
        @(negedge clk_i);
        cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
    endtask

    task automatic test_clean_miss();
        logic [255:0] fill;
        fill = make_line(32'hA000_0000);
        @(negedge clk_i);
        cpu_addr_i = 32'h0000_0120; cpu_MemRead_i = 1'b1;
        #1;
        n_cmp++; if (cpu_stall_o !== 1'b1) begin n_bad++; $display("FAIL cm_idle_stall: got %b want 1", cpu_stall_o); end
        n_cmp++; if (mem_enable_o !== 1'b0) begin n_bad++; $display("FAIL cm_idle_mem_en: got %b want 0", mem_enable_o); end
        @(negedge clk_i); #1;
        n_cmp++; if (cpu_stall_o !== 1'b1 || mem_enable_o !== 1'b0) begin n_bad++; $display("FAIL cm_miss_state: got stall=%b en=%b want 1/0", cpu_stall_o, mem_enable_o); end
        @(negedge clk_i); #1;
        n_cmp++; if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0) begin n_bad++; $display("FAIL cm_rm_ctrl: got en=%b wr=%b want 1/0", mem_enable_o, mem_write_o); end
        n_cmp++; if (mem_addr_o !== 32'h0000_0120) begin n_bad++; $display("FAIL cm_rm_addr: got %h want 00000120", mem_addr_o); end
        repeat (9) @(negedge clk_i);
        #1;
        n_cmp++; if (mem_enable_o !== 1'b1 || cpu_stall_o !== 1'b1) begin n_bad++; $display("FAIL cm_rm_hold: got en=%b stall=%b want 1/1", mem_enable_o, cpu_stall_o); end
        mem_ack_i = 1'b1; mem_data_i = fill;
        @(negedge clk_i);
        mem_ack_i = 1'b0; mem_data_i = '0;
        #1;
        n_cmp++; if (cache_sram_write_o !== 1'b1) begin n_bad++; $display("FAIL cm_ok_write: got %b want 1", cache_sram_write_o); end
        n_cmp++; if (cache_sram_tag_o !== {1'b1, 1'b0, 23'h0}) begin n_bad++; $display("FAIL cm_ok_tag: got %h want %h", cache_sram_tag_o, {1'b1, 1'b0, 23'h0}); end
        n_cmp++; if (cache_sram_data_o !== fill) begin n_bad++; $display("FAIL cm_ok_line: got %h want %h", cache_sram_data_o, fill); end
        n_cmp++; if (mem_enable_o !== 1'b0 || cpu_stall_o !== 1'b1) begin n_bad++; $display("FAIL cm_ok_ctrl: got en=%b stall=%b want 0/1", mem_enable_o, cpu_stall_o); end
        @(negedge clk_i); #1;
        n_cmp++; if (cpu_stall_o !== 1'b0) begin n_bad++; $display("FAIL cm_retry_stall: got %b want 0", cpu_stall_o); end
        n_cmp++; if (cpu_data_o !== 32'hA000_0000) begin n_bad++; $display("FAIL cm_retry_data: got %h want a0000000", cpu_data_o); end
        @(negedge clk_i);
        cpu_MemRead_i = 1'b0;
    endtask

    task automatic test_dirty_writeback();
        logic [255:0] victim;
        logic [255:0] fill;
        logic [255:0] exp_line;
        victim = make_line(32'hB000_0000);
        fill   = make_line(32'hC000_0000);
        exp_line = fill;
        exp_line[63:32] = 32'hCAFE_F00D;
        tag_arr[9]  <= {1'b1, 1'b1, 23'h1};
        data_arr[9] <= victim;
        @(negedge clk_i);
        cpu_addr_i = 32'h0000_0124; cpu_data_i = 32'hCAFE_F00D; cpu_MemWrite_i = 1'b1;
        #1;
        n_cmp++; if (cpu_stall_o !== 1'b1 || cache_sram_write_o !== 1'b0) begin n_bad++; $display("FAIL wb_idle: got stall=%b wr=%b want 1/0", cpu_stall_o, cache_sram_write_o); end
        @(negedge clk_i);
        @(negedge clk_i); #1;
        n_cmp++; if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b1) begin n_bad++; $display("FAIL wb_ctrl: got en=%b wr=%b want 1/1", mem_enable_o, mem_write_o); end
        n_cmp++; if (mem_addr_o !== 32'h0000_0320) begin n_bad++; $display("FAIL wb_addr: got %h want 00000320", mem_addr_o); end
        n_cmp++; if (mem_data_o !== victim) begin n_bad++; $display("FAIL wb_data: got %h want %h", mem_data_o, victim); end
        repeat (3) @(negedge clk_i);
        #1;
        n_cmp++; if (mem_write_o !== 1'b1 || mem_addr_o !== 32'h0000_0320) begin n_bad++; $display("FAIL wb_hold: got wr=%b addr=%h want 1/00000320", mem_write_o, mem_addr_o); end
        mem_ack_i = 1'b1; mem_data_i = '1;
        @(negedge clk_i);
        mem_ack_i = 1'b0; mem_data_i = '0;
        #1;
        n_cmp++; if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h0000_0120) begin n_bad++; $display("FAIL wb_then_fill: got en=%b wr=%b addr=%h want 1/0/00000120", mem_enable_o, mem_write_o, mem_addr_o); end
        mem_ack_i = 1'b1; mem_data_i = fill;
        @(negedge clk_i);
        mem_ack_i = 1'b0; mem_data_i = '0;
        #1;
        n_cmp++; if (cache_sram_write_o !== 1'b1 || cache_sram_tag_o !== {1'b1, 1'b0, 23'h0} || cache_sram_data_o !== fill) begin n_bad++; $display("FAIL wb_fill_write: got wr=%b tag=%h line=%h", cache_sram_write_o, cache_sram_tag_o, cache_sram_data_o); end
        @(negedge clk_i); #1;
        n_cmp++; if (cpu_stall_o !== 1'b0 || cache_sram_write_o !== 1'b1) begin n_bad++; $display("FAIL wb_retry_ctrl: got stall=%b wr=%b want 0/1", cpu_stall_o, cache_sram_write_o); end
        n_cmp++; if (cache_sram_tag_o !== {1'b1, 1'b1, 23'h0}) begin n_bad++; $display("FAIL wb_retry_tag: got %h want %h", cache_sram_tag_o, {1'b1, 1'b1, 23'h0}); end
        n_cmp++; if (cache_sram_data_o !== exp_line) begin n_bad++; $display("FAIL wb_retry_line: got %h want %h", cache_sram_data_o, exp_line); end
        @(negedge clk_i);
        cpu_MemWrite_i = 1'b0;
`ifdef DCACHE_PERF_CNT_EN
        #1;
        n_cmp++; if (hit_cnt_o !== 32'd5) begin n_bad++; $display("FAIL cnt_hits: got %0d want 5", hit_cnt_o); end
        n_cmp++; if (miss_cnt_o !== 32'd2) begin n_bad++; $display("FAIL cnt_misses: got %0d want 2", miss_cnt_o); end
`endif
    endtask

    task automatic test_reset_mid_readmiss();
        int wc0;
        @(negedge clk_i);
        cpu_addr_i = 32'h0000_00A0; cpu_MemRead_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i); #1;
        n_cmp++; if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h0000_00A0) begin n_bad++; $display("FAIL rr_in_readmiss: got en=%b addr=%h want 1/000000a0", mem_enable_o, mem_addr_o); end
        wc0 = wr_cnt;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0; cpu_MemRead_i = 1'b0;
        #1;
        n_cmp++; if (mem_enable_o !== 1'b0 || cache_sram_write_o !== 1'b0 || cpu_stall_o !== 1'b0) begin n_bad++; $display("FAIL rr_after_reset: got en=%b wr=%b stall=%b want 0/0/0", mem_enable_o, cache_sram_write_o, cpu_stall_o); end
`ifdef DCACHE_PERF_CNT_EN
        n_cmp++; if (hit_cnt_o !== 32'h0 || miss_cnt_o !== 32'h0) begin n_bad++; $display("FAIL rr_counters: got hit=%0d miss=%0d want 0/0", hit_cnt_o, miss_cnt_o); end
`endif
        mem_ack_i = 1'b1; mem_data_i = '1;
        @(negedge clk_i);
        mem_ack_i = 1'b0; mem_data_i = '0;
        #1;
        n_cmp++; if (mem_enable_o !== 1'b0 || cache_sram_write_o !== 1'b0) begin n_bad++; $display("FAIL rr_stale_ack: got en=%b wr=%b want 0/0", mem_enable_o, cache_sram_write_o); end
        n_cmp++; if (wr_cnt !== wc0) begin n_bad++; $display("FAIL rr_no_write: got %0d want %0d", wr_cnt, wc0); end
        cpu_MemRead_i = 1'b1;
        #1;
        n_cmp++; if (cpu_stall_o !== 1'b1 || mem_enable_o !== 1'b0) begin n_bad++; $display("FAIL rr_still_miss: got stall=%b en=%b want 1/0", cpu_stall_o, mem_enable_o); end
        cpu_MemRead_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_write_hit();
        test_both_high();
        test_clean_miss();
        test_dirty_writeback();
        test_reset_mid_readmiss();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
